// File: rtl/spi_sub_if.sv
// SPI subordinate bus bundle: the four SPI pins plus the byte-level
// controller side. The controller side has no backpressure: new_data is a
// one-cycle strobe that qualifies rx_byte. The consumer must take the byte
// in that cycle. rx_byte stays stable until the next strobe. tx_byte is
// sampled at cs_n fall and at each word boundary.
interface spi_sub_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              new_data;
    logic [DATA_W-1:0] rx_byte;
    logic [DATA_W-1:0] tx_byte;
    logic              active;     // debug view of the FSM: 1 = ACTIVE

    modport master (
        output sclk, cs_n, mosi, tx_byte,
        input  miso, new_data, rx_byte, active
    );

    modport slave (
        input  sclk, cs_n, mosi, tx_byte,
        output miso, new_data, rx_byte, active
    );
endinterface

// File: rtl/spi_sub.sv
// SPI mode-0 subordinate, MSB first. The SPI pins are synchronised into
// the clk domain. A two-state FSM shifts MOSI in on sclk rise and MISO out
// on sclk fall.
module spi_sub #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    spi_sub_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   armed_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              done_q, done_d;
    logic              new_data_q;
    logic [DATA_W-1:0] rx_byte_q;

    logic sclk_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    // Pin synchronisers and edge-detect history. They reset to idle bus levels.
    // fill_q marks when the chains hold real pin samples. cs_fall is armed
    // only after a genuine high cs_n, so a cs_n held low through reset
    // cannot restart a transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            if (fill_q[SYNC_STAGES] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sclk_s & ~sclk_prev_q;
    assign sck_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // FSM next state and shift-register updates. cs_rise takes priority over sclk edges.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_d      = bus.tx_byte;
                    bit_cnt_d = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sck_rise) begin
                    rx_d = {rx_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_d = bus.tx_byte;
                    end else begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. A finished word is published one
    // cycle after its last bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            done_q     <= 1'b0;
            new_data_q <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            done_q     <= done_d;
            new_data_q <= done_q;
            if (done_q) begin
                rx_byte_q <= rx_q;
            end
        end
    end

    // MISO is the MSB of the transmit shifter while selected, and 0 otherwise.
    assign bus.miso     = (state_q == ACTIVE) & tx_q[DATA_W-1];
    assign bus.new_data = new_data_q;
    assign bus.rx_byte  = rx_byte_q;
    assign bus.active   = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_sub.sv
// Directed bench for spi_sub. A bit-banged mode-0 master drives the pins.
// The monitor pops expected receive bytes from a queue on every new_data pulse.
module tb_spi_sub;
    localparam int HALF = 6;   // sclk half period in clk cycles

    logic clk;
    logic rst;
    spi_sub_if #(.DATA_W(8)) bus ();

    spi_sub #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] exp_q[$];
    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_pulses = 0;
    logic       nd_prev  = 1'b0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every new_data pulse must match the head of exp_q.
    always @(negedge clk) begin
        if (bus.new_data === 1'b1) begin
            n_pulses++;
            chk("new_data_single_cycle", 32'(nd_prev), 32'd0);
            chk("new_data_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("rx_byte", 32'(bus.rx_byte), 32'(exp_q.pop_front()));
            end
        end
        nd_prev = bus.new_data;
    end

    task automatic cs_begin();
        bus.cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_end();
        wait_clks(HALF);
        bus.cs_n = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // Send nbits of d, MSB first, and collect MISO at each rising sclk.
    // With do_swap set, tx_byte is replaced by swap_val as soon as
    // new_data appears in the last high phase.
    task automatic send_word(input logic [7:0] d, input int nbits,
                             input logic [7:0] exp_miso, input bit check_miso,
                             input bit do_swap, input logic [7:0] swap_val);
        logic [7:0] got;
        bit swapped;
        got = '0;
        swapped = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = d[7-i];
            wait_clks(HALF);
            bus.sclk = 1'b1;
            got = {got[6:0], bus.miso};
            if (do_swap && i == nbits - 1) begin
                for (int k = 0; k < HALF; k++) begin
                    @(negedge clk);
                    if (!swapped && bus.new_data === 1'b1) begin
                        bus.tx_byte = swap_val;
                        swapped = 1'b1;
                    end
                end
                chk("tx_swap_seen_new_data", 32'(swapped), 32'd1);
            end else begin
                wait_clks(HALF);
            end
            bus.sclk = 1'b0;
        end
        if (check_miso) chk("miso_word", 32'(got), 32'(exp_miso));
    endtask

    initial begin
        // T1 reset with random pins
        rst         = 1'b0;
        bus.sclk    = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_byte = '0;
        for (int i = 0; i < 3; i++) begin
            bus.sclk    = 1'($urandom_range(0, 1));
            bus.cs_n    = 1'($urandom_range(0, 1));
            bus.mosi    = 1'($urandom_range(0, 1));
            bus.tx_byte = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        chk("reset_miso", 32'(bus.miso), 32'd0);
        chk("reset_new_data", 32'(bus.new_data), 32'd0);
        chk("reset_rx_byte", 32'(bus.rx_byte), 32'd0);
        chk("reset_active", 32'(bus.active), 32'd0);
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_clks(8);

        // T2 single word
        bus.tx_byte = 8'hA5;
        cs_begin();
        chk("t2_active", 32'(bus.active), 32'd1);
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 8, 8'hA5, 1'b1, 1'b0, 8'h00);
        cs_end();
        chk("t2_pending", 32'(exp_q.size()), 32'd0);
        chk("t2_rx_byte", 32'(bus.rx_byte), 32'h3C);
        chk("t2_miso_idle", 32'(bus.miso), 32'd0);

        // T3 two-word read with tx update after the first new_data
        bus.tx_byte = 8'h00;
        cs_begin();
        exp_q.push_back(8'h01);
        send_word(8'h01, 8, 8'h00, 1'b1, 1'b1, 8'h5A);
        exp_q.push_back(8'h00);
        send_word(8'h00, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
        cs_end();
        chk("t3_pending", 32'(exp_q.size()), 32'd0);
        chk("t3_rx_byte", 32'(bus.rx_byte), 32'h00);

        // T4 abort after 5 bits, then a clean word
        cs_begin();
        send_word(8'hFF, 5, 8'h00, 1'b0, 1'b0, 8'h00);
        cs_end();
        chk("t4_rx_unchanged", 32'(bus.rx_byte), 32'h00);
        chk("t4_active", 32'(bus.active), 32'd0);
        cs_begin();
        exp_q.push_back(8'h81);
        send_word(8'h81, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
        cs_end();
        chk("t4_pending", 32'(exp_q.size()), 32'd0);
        chk("t4_rx_byte", 32'(bus.rx_byte), 32'h81);

        // T5 three back-to-back words in one window
        begin
            int p0;
            p0 = n_pulses;
            cs_begin();
            exp_q.push_back(8'h83);
            send_word(8'h83, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
            exp_q.push_back(8'h5A);
            send_word(8'h5A, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
            exp_q.push_back(8'hC3);
            send_word(8'hC3, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
            cs_end();
            chk("t5_pulse_count", 32'(n_pulses - p0), 32'd3);
            chk("t5_pending", 32'(exp_q.size()), 32'd0);
        end

        // T6 reset mid-word with cs_n held low
        cs_begin();
        send_word(8'hFF, 3, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(1);
        chk("t6_rx_after_reset", 32'(bus.rx_byte), 32'd0);
        chk("t6_active_after_reset", 32'(bus.active), 32'd0);
        send_word(8'hFF, 8, 8'h00, 1'b1, 1'b0, 8'h00);
        wait_clks(HALF);
        chk("t6_still_idle", 32'(bus.active), 32'd0);
        chk("t6_rx_unchanged", 32'(bus.rx_byte), 32'd0);
        cs_end();
        cs_begin();
        exp_q.push_back(8'h42);
        send_word(8'h42, 8, 8'h5A, 1'b1, 1'b0, 8'h00);
        cs_end();
        chk("t6_pending", 32'(exp_q.size()), 32'd0);
        chk("t6_rx_byte", 32'(bus.rx_byte), 32'h42);

        chk("total_pulses", 32'(n_pulses), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
